// File: rtl/qtable_update_sequencer_pkg.sv
// Shared definitions for the Q-table update sequencer: field widths,
// packet-type encodings and sequencer state encoding.
package qtable_update_sequencer_pkg;

  localparam int WORD_WIDTH_DFLT = 16;
  localparam int PKT_TYPE_W      = 3;

  typedef enum logic [2:0] {
    PKT_HELLO = 3'b000,
    PKT_JOIN  = 3'b001,
    PKT_ADV   = 3'b010,
    PKT_ACK   = 3'b011,
    PKT_REQ   = 3'b100,
    PKT_DATA  = 3'b101,
    PKT_RSV6  = 3'b110,
    PKT_RSV7  = 3'b111
  } pkt_type_e;

  // Only DATA packets reach the updater unless a build overrides the mask.
  localparam logic [7:0] TYPE_MASK_DFLT = 8'b1 << PKT_DATA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_POP   = 2'd3
  } seq_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/qtable_update_sequencer_pkt_fifo.sv
// Packet queue: power-of-two depth, wrapping pointers, full/empty from an
// occupancy count. Storage is not reset; the pointers define validity.
module pkt_fifo #(
  parameter int WIDTH = 99,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/qtable_update_sequencer.sv
// Filters received packets by type, queues admitted ones and hands them one
// at a time to the Q-table updater, aborting an update after TIMEOUT cycles.
module qtable_update_sequencer
  import qtable_update_sequencer_pkg::*;
#(
  parameter int         WORD_WIDTH = WORD_WIDTH_DFLT,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 64,
  parameter logic [7:0] TYPE_MASK  = TYPE_MASK_DFLT
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [WORD_WIDTH-1:0] rx_sourceID,
  input  logic [WORD_WIDTH-1:0] rx_sourceHops,
  input  logic [WORD_WIDTH-1:0] rx_clusterID,
  input  logic [WORD_WIDTH-1:0] rx_energyLeft,
  input  logic [WORD_WIDTH-1:0] rx_qValue,
  input  logic [WORD_WIDTH-1:0] rx_knownCH,
  input  logic [2:0]            rx_packetType,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fSourceHops,
  output logic [WORD_WIDTH-1:0] fClusterID,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [WORD_WIDTH-1:0] fKnownCH,
  output logic [2:0]            fPacketType,
  output logic                  upd_en,
  input  logic                  upd_done,
  output logic                  busy,
  output logic                  timeout_flag,
  output logic [7:0]            drop_count
);
  localparam int PKT_W  = 6 * WORD_WIDTH + PKT_TYPE_W;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  seq_state_e        r_state;
  seq_state_e        w_next;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_timeout;
  logic [7:0]        r_drop_cnt;
  logic [PKT_W-1:0]  r_pkt;
  logic [PKT_W-1:0]  w_push_data;
  logic [PKT_W-1:0]  w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_admit;
  logic              w_push;
  logic              w_pop;
  logic              w_upd_en;
  logic              w_wait_expired;

  // Gated by reset so nothing can be taken in while reset is held.
  assign rx_ready    = !w_full && !nrst;
  assign w_accept    = rx_valid && rx_ready;
  assign w_admit     = TYPE_MASK[rx_packetType];
  assign w_push      = w_accept && w_admit;
  assign w_pop       = (r_state == ST_POP);
  assign w_push_data = {rx_packetType, rx_sourceID, rx_sourceHops, rx_clusterID,
                        rx_energyLeft, rx_qValue, rx_knownCH};

  pkt_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_wait_expired = (r_wait_cnt == WCNT_W'(TIMEOUT));

  always_comb begin
    w_next   = r_state;
    w_upd_en = 1'b0;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_next = ST_ISSUE;
      ST_ISSUE: begin
        w_upd_en = 1'b1;
        w_next   = ST_WAIT;
      end
      ST_WAIT:  if (upd_done || w_wait_expired) w_next = ST_POP;
      ST_POP:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
      r_drop_cnt <= '0;
      r_pkt      <= '0;
    end else begin
      r_state <= w_next;
      // Counter reads 1 in the first WAIT cycle.
      case (r_state)
        ST_ISSUE: r_wait_cnt <= WCNT_W'(1);
        ST_WAIT:  if (w_next == ST_WAIT) r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
        ST_POP:   r_wait_cnt <= '0;
        default:  r_wait_cnt <= r_wait_cnt;
      endcase
      // A completion arriving on the last allowed cycle wins over the abort.
      if ((r_state == ST_WAIT) && w_wait_expired && !upd_done) r_timeout <= 1'b1;
      if (w_accept && !w_admit) r_drop_cnt <= sat_inc8(r_drop_cnt);
      if ((r_state == ST_IDLE) && !w_empty) r_pkt <= w_head;
    end
  end

  assign {fPacketType, fSourceID, fSourceHops, fClusterID,
          fEnergyLeft, fQValue, fKnownCH} = r_pkt;
  assign upd_en       = w_upd_en;
  assign busy         = (r_state != ST_IDLE) || !w_empty;
  assign timeout_flag = r_timeout;
  assign drop_count   = r_drop_cnt;

endmodule

// File: tb/tb_qtable_update_sequencer.sv
// Self-checking bench: directed table, hand-written corner sequences and a
// randomized run against a transaction-level queue model.
module tb_qtable_update_sequencer;
  localparam int         W      = 16;
  localparam int         DEPTH  = 4;
  localparam int         T      = 64;
  localparam logic [7:0] MASK   = 8'b0010_0000;
  localparam logic [2:0] DATA_T = 3'b101;

  logic         clk = 1'b0;
  logic         nrst, rx_valid, rx_ready, upd_en, upd_done, busy, timeout_flag;
  logic [W-1:0] rx_sourceID, rx_sourceHops, rx_clusterID, rx_energyLeft, rx_qValue, rx_knownCH;
  logic [2:0]   rx_packetType, fPacketType;
  logic [W-1:0] fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH;
  logic [7:0]   drop_count;

  typedef struct {
    logic [W-1:0] sid, hops, cid, en, q, kch;
    logic [2:0]   t;
  } pkt_t;

  typedef struct {
    logic [2:0] ptype;
    logic       exp_issue;
    logic [7:0] exp_drop;
  } vec_t;

  qtable_update_sequencer #(
    .WORD_WIDTH (W), .FIFO_DEPTH (DEPTH), .TIMEOUT (T), .TYPE_MASK (MASK)
  ) dut (
    .clk (clk), .nrst (nrst), .rx_valid (rx_valid), .rx_ready (rx_ready),
    .rx_sourceID (rx_sourceID), .rx_sourceHops (rx_sourceHops),
    .rx_clusterID (rx_clusterID), .rx_energyLeft (rx_energyLeft),
    .rx_qValue (rx_qValue), .rx_knownCH (rx_knownCH), .rx_packetType (rx_packetType),
    .fSourceID (fSourceID), .fSourceHops (fSourceHops), .fClusterID (fClusterID),
    .fEnergyLeft (fEnergyLeft), .fQValue (fQValue), .fKnownCH (fKnownCH),
    .fPacketType (fPacketType), .upd_en (upd_en), .upd_done (upd_done),
    .busy (busy), .timeout_flag (timeout_flag), .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   gcyc  = 0;
  vec_t tbl[8];
  pkt_t p, p36;
  pkt_t mq[$];
  int   en_at, sent, acc, saw, anybusy, checked_low;
  int   en_ids[$];
  int   en_cyc[$];
  int   c, issue_c, end_c, done_c, tfc, d, k_wait, mdrop;
  bit   srv, mflag, exp_ready, was_idle_ne, took;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pk(input pkt_t x);
    return 128'({x.t, x.sid, x.hops, x.cid, x.en, x.q, x.kch});
  endfunction

  function automatic logic [127:0] fo();
    return 128'({fPacketType, fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH});
  endfunction

  function automatic pkt_t mk(input int id, input logic [2:0] t);
    pkt_t x;
    x.sid  = W'(id);
    x.hops = W'(id + 1);
    x.cid  = W'(id * 3);
    x.en   = ~W'(id);
    x.q    = W'(id << 4);
    x.kch  = W'(id) ^ 16'h0055;
    x.t    = t;
    return x;
  endfunction

  function automatic pkt_t rnd_pkt();
    pkt_t x;
    x.sid  = W'($urandom);
    x.hops = W'($urandom);
    x.cid  = W'($urandom);
    x.en   = W'($urandom);
    x.q    = W'($urandom);
    x.kch  = W'($urandom);
    x.t    = ($urandom_range(0, 1) == 1) ? DATA_T : 3'($urandom_range(0, 7));
    return x;
  endfunction

  task automatic drive(input pkt_t x);
    rx_sourceID   = x.sid;
    rx_sourceHops = x.hops;
    rx_clusterID  = x.cid;
    rx_energyLeft = x.en;
    rx_qValue     = x.q;
    rx_knownCH    = x.kch;
    rx_packetType = x.t;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    gcyc++;
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    rx_valid = 1'b0;
    upd_done = 1'b0;
    drive(mk(0, 3'd0));
    tick();
    tick();
    nrst = 1'b0;
    #1;
  endtask

  // Leaves the bench in the ISSUE cycle of the sent packet.
  task automatic send_one(input pkt_t x);
    drive(x);
    rx_valid = 1'b1;
    chk("send_ready", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
    chk("lat_early", upd_en, 0);
    tick();
    chk("lat_issue", upd_en, 1);
  endtask

  task automatic send_burst(input int n, input int base, output int first_en);
    int g0;
    first_en = -1;
    g0 = gcyc;
    for (int i = 0; i < n; i++) begin
      drive(mk(base + i, DATA_T));
      rx_valid = 1'b1;
      if (upd_en && first_en < 0) first_en = gcyc;
      tick();
    end
    rx_valid = 1'b0;
    chk("burst_lat", first_en, g0 + 2);
  endtask

  initial begin
    tbl[0] = '{3'd5, 1'b1, 8'd0};
    tbl[1] = '{3'd0, 1'b0, 8'd1};
    tbl[2] = '{3'd1, 1'b0, 8'd2};
    tbl[3] = '{3'd2, 1'b0, 8'd3};
    tbl[4] = '{3'd5, 1'b1, 8'd3};
    tbl[5] = '{3'd3, 1'b0, 8'd4};
    tbl[6] = '{3'd6, 1'b0, 8'd5};
    tbl[7] = '{3'd7, 1'b0, 8'd6};

    // Reset values, then first cycle after release
    nrst = 1'b1;
    rx_valid = 1'b0;
    upd_done = 1'b0;
    drive(mk(0, 3'd0));
    tick();
    tick();
    chk("rst_ready", rx_ready, 0);
    chk("rst_upd_en", upd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tflag", timeout_flag, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_f", fo(), 0);
    nrst = 1'b0;
    #1;
    chk("rel_ready", rx_ready, 1);

    // Type filter table
    for (int i = 0; i < 8; i++) begin
      drive(mk(40 + i, tbl[i].ptype));
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      saw = 0;
      for (int k = 0; k < 3; k++) begin
        if (upd_en) begin
          saw = 1;
          tick();
          upd_done = 1'b1;
          tick();
          upd_done = 1'b0;
          tick();
          break;
        end
        tick();
      end
      chk("tbl_issue", saw, tbl[i].exp_issue);
      chk("tbl_drop", drop_count, tbl[i].exp_drop);
      chk("tbl_busy", busy, 0);
    end

    // Single DATA packet, completion 5 cycles after the start pulse
    do_reset();
    p36.sid = 16'd1; p36.hops = 16'd2; p36.cid = 16'd7;
    p36.en = 16'h8000; p36.q = 16'h3000; p36.kch = 16'd4; p36.t = DATA_T;
    send_one(p36);
    chk("one_f_issue", fo(), pk(p36));
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("one_en_low", upd_en, 0);
      chk("one_f_wait", fo(), pk(p36));
      chk("one_busy_wait", busy, 1);
      if (k == 5) upd_done = 1'b1;
    end
    tick();
    upd_done = 1'b0;
    chk("one_f_pop", fo(), pk(p36));
    chk("one_busy_pop", busy, 1);
    tick();
    chk("one_busy_idle", busy, 0);
    chk("one_tflag", timeout_flag, 0);
    chk("one_en_idle", upd_en, 0);

    // Five back-to-back packets, updater never answers
    do_reset();
    sent = 0; acc = 0; checked_low = 0;
    en_ids.delete();
    en_cyc.delete();
    for (int cy = 0; cy < 600; cy++) begin
      if (upd_en) begin
        en_ids.push_back(int'(fSourceID));
        en_cyc.push_back(cy);
      end
      if (acc == 4 && checked_low == 0) begin
        chk("b2b_ready_low", rx_ready, 0);
        checked_low = 1;
      end
      if (sent < 5) begin
        drive(mk(10 + sent, DATA_T));
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
      end
      took = rx_valid && rx_ready;
      tick();
      if (took) begin
        sent++;
        acc++;
      end
      if (sent == 5 && en_ids.size() == 5 && !busy) break;
    end
    rx_valid = 1'b0;
    chk("b2b_issues", en_ids.size(), 5);
    for (int i = 0; i < en_ids.size(); i++) chk("b2b_order", en_ids[i], 10 + i);
    for (int i = 1; i < en_cyc.size(); i++) chk("b2b_interval", en_cyc[i] - en_cyc[i-1], T + 3);
    chk("b2b_tflag", timeout_flag, 1);
    chk("b2b_drained", busy, 0);

    // Filtered type, then drop counter saturation
    do_reset();
    drive(mk(5, 3'b001));
    rx_valid = 1'b1;
    chk("drop_ready", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
    saw = 0;
    for (int k = 0; k < 3; k++) begin
      if (upd_en) saw = 1;
      tick();
    end
    chk("drop_no_issue", saw, 0);
    chk("drop_one", drop_count, 1);
    chk("drop_not_busy", busy, 0);
    rx_valid = 1'b1;
    for (int k = 0; k < 299; k++) tick();
    rx_valid = 1'b0;
    chk("drop_sat", drop_count, 255);

    // Completion on the last allowed WAIT cycle
    do_reset();
    send_one(mk(77, DATA_T));
    for (int k = 1; k <= T; k++) begin
      tick();
      if (k == T) upd_done = 1'b1;
    end
    tick();
    upd_done = 1'b0;
    chk("edge_tflag_pop", timeout_flag, 0);
    chk("edge_busy_pop", busy, 1);
    tick();
    chk("edge_busy_idle", busy, 0);
    chk("edge_tflag_idle", timeout_flag, 0);

    // Reset in the middle of WAIT with three packets queued
    do_reset();
    send_burst(4, 30, en_at);
    while (gcyc < en_at + 10) tick();
    nrst = 1'b1;
    tick();
    chk("mid_rst_ready", rx_ready, 0);
    saw = int'(upd_en);
    tick();
    if (upd_en) saw = 1;
    nrst = 1'b0;
    #1;
    chk("mid_rst_f", fo(), 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tflag", timeout_flag, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_en", upd_en, 0);
    chk("mid_rst_rel_ready", rx_ready, 1);
    anybusy = 0;
    for (int k = 0; k < 20; k++) begin
      if (upd_en) saw = 1;
      if (busy) anybusy = 1;
      tick();
    end
    chk("mid_rst_no_issue", saw, 0);
    chk("mid_rst_idle", anybusy, 0);

    // Push attempt while popping a full queue
    do_reset();
    send_burst(4, 20, en_at);
    while (gcyc < en_at + T + 1) tick();
    chk("full_pop_ready", rx_ready, 0);
    drive(mk(99, DATA_T));
    rx_valid = 1'b1;
    tick();
    chk("after_pop_ready", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
    chk("refill_full", rx_ready, 0);
    chk("next_issue", upd_en, 1);
    chk("next_head", fSourceID, 21);

    // Randomized run against the queue model
    do_reset();
    c = 0; srv = 0; mdrop = 0; mflag = 0; tfc = -1;
    issue_c = -10; end_c = -10; done_c = -10;
    mq.delete();
    for (int n = 0; n < 2500; n++) begin
      exp_ready = (mq.size() < DEPTH);
      if (tfc >= 0 && c >= tfc) mflag = 1;
      chk("rnd_ready", rx_ready, exp_ready);
      chk("rnd_upd_en", upd_en, srv && (c == issue_c));
      chk("rnd_busy", busy, srv || (mq.size() > 0));
      chk("rnd_tflag", timeout_flag, mflag);
      chk("rnd_drop", drop_count, mdrop);
      if (srv && c >= issue_c && c <= end_c) chk("rnd_f", fo(), pk(mq[0]));

      p = rnd_pkt();
      drive(p);
      rx_valid = ($urandom_range(0, 99) < 45);
      if (srv && c > issue_c && c < end_c) upd_done = (c == done_c);
      else upd_done = ($urandom_range(0, 3) == 0);

      was_idle_ne = !srv && (mq.size() > 0);
      if (srv && c == end_c) begin
        void'(mq.pop_front());
        srv = 0;
      end
      if (rx_valid && exp_ready) begin
        if (MASK[p.t]) mq.push_back(p);
        else if (mdrop < 255) mdrop++;
      end
      if (was_idle_ne) begin
        srv = 1;
        issue_c = c + 1;
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5, 6: d = $urandom_range(1, 6);
          7, 8:                d = $urandom_range(T - 2, T + 1);
          default:             d = T + 5;
        endcase
        k_wait = (d <= T) ? d : T;
        end_c  = issue_c + k_wait + 1;
        done_c = (d <= T) ? issue_c + d : -10;
        if (d > T && tfc < 0) tfc = end_c;
      end
      tick();
      c++;
    end
    rx_valid = 1'b0;
    upd_done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qtable_update_sequencer.md
QTABLE_UPDATE_SEQUENCER -- requirements
Module: qtable_update_sequencer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, giving the width of every packet field.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the packet queue depth (power of two, 2..16).
REQ-003 SHALL have parameter TIMEOUT, default 64, giving the maximum WAIT cycles before abort.
REQ-004 SHALL have parameter TYPE_MASK, default 8'b0010_0000, where bit k=1 admits packetType k.
REQ-005 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port nrst, input, 1, reset, synchronous and active-high (1 = reset).
REQ-007 SHALL have port rx_valid, input, 1, received packet present.
REQ-008 SHALL have port rx_ready, output, 1, sequencer accepts packet this cycle.
REQ-009 SHALL have ports rx_sourceID, rx_sourceHops, rx_clusterID, rx_energyLeft, rx_qValue, rx_knownCH, input, WORD_WIDTH each, packet fields.
REQ-010 SHALL have port rx_packetType, input, 3, packet type.
REQ-011 SHALL have ports fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH, output, WORD_WIDTH each, fields to Q-table updater.
REQ-012 SHALL have port fPacketType, output, 3, type to updater.
REQ-013 SHALL have port upd_en, output, 1, one-cycle start pulse to updater.
REQ-014 SHALL have port upd_done, input, 1, updater completion.
REQ-015 SHALL have ports busy (1), timeout_flag (1), drop_count (8), output, status.

Function
REQ-016 SHALL accept a packet when rx_valid && rx_ready; rx_ready = !full, from registered occupancy only.
REQ-017 SHALL, on accept with TYPE_MASK[rx_packetType]=0, discard the packet and increment drop_count, saturating at 255.
REQ-018 SHALL enqueue admitted packets (all 7 fields) in a FIFO_DEPTH-entry FIFO with wrapping pointers and full/empty from a count.
REQ-019 SHALL implement FSM IDLE, ISSUE, WAIT, POP.
REQ-020 IDLE -> ISSUE when FIFO non-empty; otherwise stay.
REQ-021 ISSUE: upd_en=1 for exactly this cycle; -> WAIT unconditionally.
REQ-022 WAIT: count cycles from 1; on upd_done -> POP; if count reaches TIMEOUT without upd_done -> POP and set timeout_flag.
REQ-023 upd_done and timeout in the same cycle SHALL be treated as done (timeout_flag not set).
REQ-024 POP: remove FIFO head, clear wait counter; -> IDLE.
REQ-025 f* outputs SHALL equal the FIFO head, registered, stable from ISSUE through POP.
REQ-026 upd_done in IDLE, ISSUE or POP SHALL be ignored.
REQ-027 Simultaneous push and pop SHALL keep count unchanged; when full, no push occurs even if popping that cycle.
REQ-028 busy SHALL be 1 in any state other than IDLE, or when the FIFO is non-empty.
REQ-029 Latency: packet accepted at edge N into an empty FIFO with FSM in IDLE -> upd_en high in cycle N+2.
REQ-030 timeout_flag SHALL be sticky until reset.

Reset
REQ-031 nrst=1 at a rising edge SHALL force IDLE, empty FIFO, count 0, rx_ready=0 during reset, upd_en=0, busy=0, timeout_flag=0, drop_count=0, all f* = 0.
REQ-032 Reset mid-WAIT SHALL abandon the in-flight packet and all queued packets without a pulse on upd_en.
REQ-033 First cycle after reset release: rx_ready=1.

Structure
REQ-034 WORD_WIDTH, packet-type encodings (DATA=3'b101 etc.) and FSM state encoding SHALL live in a shared package.
REQ-035 The FIFO SHALL be a sub-module named pkt_fifo; FSM, filter and counters in the top.

Verification
REQ-036 One DATA packet (ID 1, hops 2, energy 16'h8000, Q 16'h3000) accepted; upd_done 5 cycles after upd_en -> upd_en one cycle at N+2, f* hold values until POP, busy drops after POP.
REQ-037 Five back-to-back DATA packets, upd_done held low -> rx_ready low after 4 accepts; each timeout after 64 WAIT cycles, timeout_flag=1, queue drains in order.
REQ-038 Packet with type 3'b001 -> accepted, no upd_en, drop_count=1; 300 such packets -> drop_count=255.
REQ-039 upd_done asserted on the 64th WAIT cycle -> POP, timeout_flag stays 0.
REQ-040 nrst asserted mid-WAIT with 3 queued -> after release FIFO empty, IDLE, all outputs 0, no upd_en.
REQ-041 Push while POP on full FIFO -> push refused (rx_ready=0), count becomes FIFO_DEPTH-1.
